cpu_mem_arbiter: RTL

- Shares the single memory bus port between instruction fetch (IF) and the load/store data path (D).
- Only one transaction is outstanding at a time.
- D has fixed priority, with a starvation guard for IF.
- A bus watchdog turns a hung access into a fault response, which the control/trap logic raises as an access-fault exception.

---
 rtl/cpu_mem_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/cpu_mem_arbiter.sv
// Shares one memory bus port between instruction fetch and the load/store path.
// One access in flight at a time; data side wins unless fetch has been starved too long.
module cpu_mem_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    if_req_valid,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    output logic                    if_req_ready,
    output logic                    if_rsp_valid,
    output logic [DATA_WIDTH-1:0]   if_rdata,
    output logic                    if_fault,

    input  logic                    d_req_valid,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH/8-1:0] d_wstrb,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    output logic                    d_req_ready,
    output logic                    d_rsp_valid,
    output logic [DATA_WIDTH-1:0]   d_rdata,
    output logic                    d_fault,

    output logic                    bus_valid,
    output logic [ADDR_WIDTH-1:0]   bus_addr,
    output logic [DATA_WIDTH/8-1:0] bus_wstrb,
    output logic [DATA_WIDTH-1:0]   bus_wdata,
    input  logic                    bus_ready,
    input  logic [DATA_WIDTH-1:0]   bus_rdata
);

    localparam int SW = DATA_WIDTH / 8;
    localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam int TW = $clog2(TIMEOUT + 2);

    typedef enum logic [1:0] {
        IDLE,
        BUS_IF,
        BUS_D,
        RESP
    } state_t;

    state_t        state;
    logic [CW-1:0] starve_cnt;
    logic [TW-1:0] timeout_cnt;

    logic starved;
    logic grant_d;
    logic grant_if;
    logic timeout_hit;
    logic access_done;

    // Fixed data priority, overridden once fetch has lost STARVE_LIMIT times in a row.
    always_comb begin
        starved      = (starve_cnt >= CW'(STARVE_LIMIT));
        grant_d      = d_req_valid && !(if_req_valid && starved);
        grant_if     = if_req_valid && !grant_d;
        d_req_ready  = rst_n && (state == IDLE) && grant_d;
        if_req_ready = rst_n && (state == IDLE) && grant_if;
        bus_valid    = (state == BUS_IF) || (state == BUS_D);
        timeout_hit  = (TIMEOUT != 0) && (timeout_cnt == TW'(TIMEOUT - 1));
        access_done  = bus_ready || timeout_hit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            starve_cnt   <= '0;
            timeout_cnt  <= '0;
            bus_addr     <= '0;
            bus_wstrb    <= '0;
            bus_wdata    <= '0;
            if_rsp_valid <= 1'b0;
            if_rdata     <= '0;
            if_fault     <= 1'b0;
            d_rsp_valid  <= 1'b0;
            d_rdata      <= '0;
            d_fault      <= 1'b0;
        end else begin
            if_rsp_valid <= 1'b0;
            d_rsp_valid  <= 1'b0;
            case (state)
                IDLE: begin
                    timeout_cnt <= '0;
                    if (!if_req_valid) begin
                        starve_cnt <= '0;
                    end
                    if (grant_d) begin
                        bus_addr  <= d_addr;
                        bus_wstrb <= d_wstrb;
                        bus_wdata <= d_wdata;
                        state     <= BUS_D;
                        // A data grant only happens with fetch waiting while not yet starved,
                        // so the increment can never pass STARVE_LIMIT.
                        if (if_req_valid) begin
                            starve_cnt <= starve_cnt + CW'(1);
                        end
                    end else if (grant_if) begin
                        bus_addr   <= if_addr;
                        bus_wstrb  <= '0;
                        bus_wdata  <= '0;
                        state      <= BUS_IF;
                        starve_cnt <= '0;
                    end
                end

                BUS_IF, BUS_D: begin
                    // bus_ready on the watchdog's last cycle still counts as a normal completion.
                    if (access_done) begin
                        state <= RESP;
                        if (state == BUS_IF) begin
                            if_rsp_valid <= 1'b1;
                            if_rdata     <= bus_ready ? bus_rdata : '0;
                            if_fault     <= !bus_ready;
                        end else begin
                            d_rsp_valid  <= 1'b1;
                            d_rdata      <= bus_ready ? bus_rdata : '0;
                            d_fault      <= !bus_ready;
                        end
                    end else begin
                        timeout_cnt <= timeout_cnt + TW'(1);
                    end
                end

                RESP: begin
                    timeout_cnt <= '0;
                    state       <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    logic unused_sw;
    assign unused_sw = (SW == 0);

endmodule
